// File: rtl/dual_rail_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dual_rail_pkg : shared rail indices, encodings and FSM states          |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package dual_rail_pkg;

  localparam int RAIL_T   = 1;
  localparam int RAIL_F   = 0;
  localparam int RAIL_NUM = 2;

  localparam string ENC_TP = "TP";
  localparam string ENC_FP = "FP";

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_NULL = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  // Four-phase data code: exactly one rail high, true rail for a 1.
  function automatic logic [RAIL_NUM-1:0] fp_code(input logic b);
    logic [RAIL_NUM-1:0] c;
    c         = '0;
    c[RAIL_T] = b;
    c[RAIL_F] = ~b;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer, clears to zero on reset             |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/dual_rail_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dual_rail_driver : single-rail to dual-rail (2-phase / 4-phase RZ)    |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module dual_rail_driver
  import dual_rail_pkg::*;
#(
  parameter string ENC     = "TP",
  parameter int    WIDTH   = 1,
  parameter int    TIMEOUT = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [WIDTH-1:0][RAIL_NUM-1:0]   out,
  input  logic                             ack,
  output logic                             busy,
  output logic [15:0]                      tok_cnt,
  output logic                             timeout_err
);

  localparam bit                IS_FP   = (ENC == ENC_FP);
  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);

  if (!((ENC == ENC_TP) || (ENC == ENC_FP))) begin : g_bad_enc
    $error("dual_rail_driver: ENC must be \"TP\" or \"FP\"");
  end

  state_e                          state_q, state_d;
  logic [WIDTH-1:0][RAIL_NUM-1:0]  out_q, out_d;
  logic                            ack_phase_q, ack_phase_d;
  logic [15:0]                     tok_cnt_q, tok_cnt_d;
  logic [CNT_W-1:0]                wait_cnt_q, wait_cnt_d;
  logic                            timeout_q, timeout_d;
  logic                            ack_s;
  logic                            timeout_hit;

  sync_2ff #(.WIDTH(1)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack),
    .q   (ack_s)
  );

  // The wait counter holds the cycles already completed in the current
  // busy state, so the current cycle is the TIMEOUT-th when it reads TIMEOUT-1.
  assign timeout_hit = (state_q != ST_IDLE) && (wait_cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    ack_phase_d = ack_phase_q;
    tok_cnt_d   = tok_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (IS_FP) begin
            state_d = ST_DATA;
            for (int i = 0; i < WIDTH; i++) begin
              out_d[i] = fp_code(in_data[i]);
            end
          end else begin
            state_d = ST_WAIT;
            for (int i = 0; i < WIDTH; i++) begin
              if (in_data[i]) out_d[i][RAIL_T] = ~out_q[i][RAIL_T];
              else            out_d[i][RAIL_F] = ~out_q[i][RAIL_F];
            end
          end
        end
      end
      ST_DATA: begin
        if (ack_s) begin
          state_d = ST_NULL;
          out_d   = '0;
        end
      end
      ST_NULL: begin
        if (!ack_s) begin
          state_d   = ST_IDLE;
          tok_cnt_d = tok_cnt_q + 16'd1;
        end
      end
      ST_WAIT: begin
        if (ack_s != ack_phase_q) begin
          state_d     = ST_IDLE;
          ack_phase_d = ~ack_phase_q;
          tok_cnt_d   = tok_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if ((state_q != ST_IDLE) && (wait_cnt_q != TO_LAST)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    timeout_d = timeout_q | timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      ack_phase_q <= 1'b0;
      tok_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      ack_phase_q <= ack_phase_d;
      tok_cnt_q   <= tok_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign out         = out_q;
  assign tok_cnt     = tok_cnt_q;
  assign timeout_err = timeout_q | timeout_hit;

endmodule
`default_nettype wire

// File: tb/tb_dual_rail_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dual_rail_driver : four-phase and two-phase driver bench           |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_dual_rail_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;

  logic [7:0]       fp_in_data;
  logic             fp_in_valid, fp_in_ready, fp_ack, fp_busy, fp_timeout_err;
  logic [7:0][1:0]  fp_out;
  logic [15:0]      fp_tok_cnt;

  logic [3:0]       tp_in_data;
  logic             tp_in_valid, tp_in_ready, tp_ack, tp_busy, tp_timeout_err;
  logic [3:0][1:0]  tp_out;
  logic [15:0]      tp_tok_cnt;

  dual_rail_driver #(.ENC("FP"), .WIDTH(8), .TIMEOUT(16)) u_fp (
    .clk (clk), .rst (rst),
    .in_data (fp_in_data), .in_valid (fp_in_valid), .in_ready (fp_in_ready),
    .out (fp_out), .ack (fp_ack), .busy (fp_busy),
    .tok_cnt (fp_tok_cnt), .timeout_err (fp_timeout_err)
  );

  dual_rail_driver #(.ENC("TP"), .WIDTH(4), .TIMEOUT(16)) u_tp (
    .clk (clk), .rst (rst),
    .in_data (tp_in_data), .in_valid (tp_in_valid), .in_ready (tp_in_ready),
    .out (tp_out), .ack (tp_ack), .busy (tp_busy),
    .tok_cnt (tp_tok_cnt), .timeout_err (tp_timeout_err)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [15:0] fp_model(input logic [7:0] d);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = d[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [7:0] tp_model(input logic [7:0] cur, input logic [3:0] d);
    logic [7:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (d[i]) r[2*i+1] = ~r[2*i+1];
      else      r[2*i]   = ~r[2*i];
    end
    return r;
  endfunction

  initial begin
    int         cnt;
    logic [7:0] tp_rails;
    logic [31:0] exp;

    rst = 1'b1;
    fp_in_data = '0; fp_in_valid = 1'b0; fp_ack = 1'b0;
    tp_in_data = '0; tp_in_valid = 1'b0; tp_ack = 1'b0;
    tp_rails = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk_eq("rst_fp_in_ready", 32'(fp_in_ready), 32'd1);
    chk_eq("rst_fp_busy",     32'(fp_busy),     32'd0);
    chk_eq("rst_fp_out",      32'(fp_out),      32'd0);
    chk_eq("rst_fp_tok_cnt",  32'(fp_tok_cnt),  32'd0);
    chk_eq("rst_fp_timeout",  32'(fp_timeout_err), 32'd0);
    chk_eq("rst_tp_in_ready", 32'(tp_in_ready), 32'd1);
    chk_eq("rst_tp_out",      32'(tp_out),      32'd0);

    // Reset while a four-phase token sits in DATA drops the token.
    fp_in_data = 8'h5A; fp_in_valid = 1'b1;
    sb_q.push_back(32'(fp_model(8'h5A)));
    tick();
    fp_in_valid = 1'b0;
    chk_eq("fp_drop_out", 32'(fp_out), sb_q.pop_front());
    chk_eq("fp_drop_busy", 32'(fp_busy), 32'd1);
    rst = 1'b1;
    tick();
    chk_eq("fp_midrst_out",      32'(fp_out),      32'd0);
    chk_eq("fp_midrst_in_ready", 32'(fp_in_ready), 32'd1);
    chk_eq("fp_midrst_tok_cnt",  32'(fp_tok_cnt),  32'd0);
    rst = 1'b0;
    tick();
    chk_eq("fp_postrst_in_ready", 32'(fp_in_ready), 32'd1);

    // Four-phase token 0xA5, ack three cycles after data appears.
    fp_in_data = 8'hA5; fp_in_valid = 1'b1;
    sb_q.push_back(32'(fp_model(8'hA5)));
    tick();
    fp_in_valid = 1'b0;
    fp_in_data  = 8'hFF;
    chk_eq("fp_a5_out", 32'(fp_out), sb_q.pop_front());
    chk_eq("fp_a5_in_ready", 32'(fp_in_ready), 32'd0);
    repeat (2) tick();
    chk_eq("fp_a5_hold", 32'(fp_out), 32'(fp_model(8'hA5)));
    fp_ack = 1'b1;
    cnt = 0;
    do begin tick(); cnt++; end while ((fp_out != '0) && (cnt < 20));
    chk_eq("fp_spacer_lat", 32'(cnt), 32'd3);
    chk_eq("fp_spacer_busy", 32'(fp_busy), 32'd1);
    chk_eq("fp_spacer_tok", 32'(fp_tok_cnt), 32'd0);
    fp_ack = 1'b0;
    cnt = 0;
    do begin tick(); cnt++; end while (fp_busy && (cnt < 20));
    chk_eq("fp_idle_lat", 32'(cnt), 32'd3);
    chk_eq("fp_a5_tok_cnt", 32'(fp_tok_cnt), 32'd1);
    chk_eq("fp_a5_in_ready", 32'(fp_in_ready), 32'd1);

    // No ack: the flag rises in the 16th wait cycle and the token survives.
    fp_in_data = 8'h0F; fp_in_valid = 1'b1;
    sb_q.push_back(32'(fp_model(8'h0F)));
    tick();
    fp_in_valid = 1'b0;
    chk_eq("fp_to_out", 32'(fp_out), sb_q.pop_front());
    for (int k = 1; k <= 15; k++) begin
      chk_eq("fp_to_early", 32'(fp_timeout_err), 32'd0);
      tick();
    end
    chk_eq("fp_to_cycle16", 32'(fp_timeout_err), 32'd1);
    repeat (4) tick();
    chk_eq("fp_to_no_abort", 32'(fp_out), 32'(fp_model(8'h0F)));
    fp_ack = 1'b1;
    cnt = 0;
    do begin tick(); cnt++; end while ((fp_out != '0) && (cnt < 20));
    chk_eq("fp_late_spacer", 32'(cnt), 32'd3);
    fp_ack = 1'b0;
    cnt = 0;
    do begin tick(); cnt++; end while (fp_busy && (cnt < 20));
    chk_eq("fp_late_idle", 32'(cnt), 32'd3);
    chk_eq("fp_late_tok_cnt", 32'(fp_tok_cnt), 32'd2);
    chk_eq("fp_to_sticky", 32'(fp_timeout_err), 32'd1);

    // Two-phase: 0x3 twice with in_valid held high across both handshakes.
    tp_in_data = 4'h3; tp_in_valid = 1'b1;
    tp_rails = tp_model(tp_rails, 4'h3);
    sb_q.push_back(32'(tp_rails));
    tick();
    chk_eq("tp_tok1_out", 32'(tp_out), sb_q.pop_front());
    chk_eq("tp_tok1_in_ready", 32'(tp_in_ready), 32'd0);
    chk_eq("tp_tok1_busy", 32'(tp_busy), 32'd1);
    tp_in_data = 4'hC;
    repeat (2) tick();
    chk_eq("tp_tok1_hold", 32'(tp_out), 32'(tp_rails));
    chk_eq("tp_tok1_in_ready_wait", 32'(tp_in_ready), 32'd0);
    tp_in_data = 4'h3;
    tp_ack = 1'b1;
    tp_rails = tp_model(tp_rails, 4'h3);
    sb_q.push_back(32'(tp_rails));
    cnt = 0;
    do begin tick(); cnt++; end while (tp_busy && (cnt < 20));
    chk_eq("tp_tok1_lat", 32'(cnt), 32'd3);
    chk_eq("tp_tok1_tok_cnt", 32'(tp_tok_cnt), 32'd1);
    tick();
    chk_eq("tp_tok2_out", 32'(tp_out), sb_q.pop_front());
    chk_eq("tp_tok2_busy", 32'(tp_busy), 32'd1);
    tp_ack = 1'b0;
    cnt = 0;
    do begin tick(); cnt++; end while (tp_busy && (cnt < 20));
    tp_in_valid = 1'b0;
    chk_eq("tp_tok2_lat", 32'(cnt), 32'd3);
    chk_eq("tp_tok2_tok_cnt", 32'(tp_tok_cnt), 32'd2);
    chk_eq("tp_rails_back", 32'(tp_out), 32'd0);
    tick();
    chk_eq("tp_single_accept", 32'(tp_busy), 32'd0);
    chk_eq("tp_no_timeout", 32'(tp_timeout_err), 32'd0);

    // Counter at 65535 wraps to zero on the next completion.
    force u_tp.tok_cnt_q = 16'hFFFF;
    tick();
    release u_tp.tok_cnt_q;
    tick();
    chk_eq("tp_preload", 32'(tp_tok_cnt), 32'h0000FFFF);
    tp_in_data = 4'h9; tp_in_valid = 1'b1;
    tp_rails = tp_model(tp_rails, 4'h9);
    sb_q.push_back(32'(tp_rails));
    tick();
    tp_in_valid = 1'b0;
    chk_eq("tp_wrap_out", 32'(tp_out), sb_q.pop_front());
    tp_ack = 1'b1;
    cnt = 0;
    do begin tick(); cnt++; end while (tp_busy && (cnt < 20));
    chk_eq("tp_wrap_lat", 32'(cnt), 32'd3);
    exp = 32'd0;
    chk_eq("tp_wrap_tok_cnt", 32'(tp_tok_cnt), exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
